// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: IDLE -> DECODE -> EXECUTE -> WRITEBACK | TRAP.
// Latency: strobes 3 cycles after accept (trap 2 cycles for illegal instr), 4-cycle throughput.
// Backpressure: instr_ready only in IDLE; instr_valid elsewhere is ignored. Optional macro ALU_SEQ_BRANCH_EN.
module alu_seq_ctrl #(
  parameter logic TRAP_ON_ERROR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        flagC,
  input  logic        flagZ,
  input  logic        flagError,
  input  logic        flagNegativo,
  output logic [3:0]  SEL_OP,
  output logic        srcA_SEL,
  output logic        srcB_SEL,
  output logic        reg_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        done,
  output logic        trap
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
`ifdef ALU_SEQ_BRANCH_EN
  localparam logic [6:0] OPC_BR    = 7'b1100011;
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    TRAP      = 3'd4
  } state_t;

  state_t     state, state_nxt;

  // Only opcode/funct3/funct7 matter; register and immediate fields are not used here.
  logic [6:0] opc_q;
  logic [2:0] f3_q;
  logic [6:0] f7_q;

  logic       dec_legal;
  logic [3:0] dec_op;
  logic       dec_a;
  logic       dec_b;

`ifdef ALU_SEQ_BRANCH_EN
  logic       dec_branch;
  logic       is_branch;
  logic       br_taken;
  logic       taken_now;
  logic       unused_sig;
  assign unused_sig = ^{instr[24:15], instr[11:7]};
`else
  logic       unused_sig;
  assign unused_sig = ^{flagC, flagZ, flagNegativo, instr[24:15], instr[11:7]};
`endif

  // funct3 -> ALU op; alt is funct7[5], sub_ok selects SUB on funct3 000 (R-type only).
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt, input logic sub_ok);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && sub_ok) ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = alt ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  // Instruction decode of the latched word, used during DECODE.
  always_comb begin
    dec_legal  = 1'b0;
    dec_op     = OP_ADD;
    dec_a      = 1'b0;
    dec_b      = 1'b0;
`ifdef ALU_SEQ_BRANCH_EN
    dec_branch = 1'b0;
`endif
    case (opc_q)
      OPC_R: begin
        dec_legal = (f7_q == 7'b0000000) || (f7_q == 7'b0100000);
        dec_op    = alu_map(f3_q, f7_q[5], 1'b1);
      end
      OPC_I: begin
        dec_legal = 1'b1;
        dec_b     = 1'b1;
        dec_op    = alu_map(f3_q, f7_q[5], 1'b0);
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_a     = 1'b1;
        dec_b     = 1'b1;
      end
`ifdef ALU_SEQ_BRANCH_EN
      OPC_BR: begin
        dec_legal  = (f3_q != 3'b010) && (f3_q != 3'b011);
        dec_op     = OP_SUB;
        dec_branch = 1'b1;
      end
`endif
      default: dec_legal = 1'b0;
    endcase
  end

`ifdef ALU_SEQ_BRANCH_EN
  // Branch condition from the SUB flags; flagC=1 means no borrow (A >= B unsigned).
  always_comb begin
    taken_now = 1'b0;
    case (f3_q)
      3'b000:  taken_now = flagZ;
      3'b001:  taken_now = !flagZ;
      3'b100:  taken_now = flagNegativo;
      3'b101:  taken_now = !flagNegativo;
      3'b110:  taken_now = !flagC;
      3'b111:  taken_now = flagC;
      default: taken_now = 1'b0;
    endcase
  end
`endif

  // Next-state and Moore strobes; all strobes come from the state so a reset cancels them.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    reg_we      = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    done        = 1'b0;
    trap        = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = DECODE;
      end
      DECODE:  state_nxt = dec_legal ? EXECUTE : TRAP;
      EXECUTE: state_nxt = (TRAP_ON_ERROR && flagError) ? TRAP : WRITEBACK;
      WRITEBACK: begin
        pc_we     = 1'b1;
        done      = 1'b1;
`ifdef ALU_SEQ_BRANCH_EN
        reg_we    = !is_branch;
        pc_src    = is_branch && br_taken;
`else
        reg_we    = 1'b1;
`endif
        state_nxt = IDLE;
      end
      TRAP: begin
        trap      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, instruction latch and ALU control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      opc_q    <= '0;
      f3_q     <= '0;
      f7_q     <= '0;
      SEL_OP   <= OP_ADD;
      srcA_SEL <= 1'b0;
      srcB_SEL <= 1'b0;
`ifdef ALU_SEQ_BRANCH_EN
      is_branch <= 1'b0;
      br_taken  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && instr_valid) begin
        opc_q <= instr[6:0];
        f3_q  <= instr[14:12];
        f7_q  <= instr[31:25];
      end
      if (state == DECODE && dec_legal) begin
        SEL_OP   <= dec_op;
        srcA_SEL <= dec_a;
        srcB_SEL <= dec_b;
`ifdef ALU_SEQ_BRANCH_EN
        is_branch <= dec_branch;
`endif
      end
`ifdef ALU_SEQ_BRANCH_EN
      if (state == EXECUTE) br_taken <= taken_now;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: two instances (TRAP_ON_ERROR 1 and 0) share stimulus.
// Stimulus pushes expected retire/trap records; a negedge monitor pops and compares.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        flagC, flagZ, flagError, flagNegativo;

  logic       rdy1, a1, b1, rwe1, pwe1, psrc1, done1, trap1;
  logic [3:0] op1;
  logic       rdy0, a0, b0, rwe0, pwe0, psrc0, done0, trap0;
  logic [3:0] op0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.TRAP_ON_ERROR(1'b1)) dut1 (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(rdy1),
    .flagC(flagC), .flagZ(flagZ), .flagError(flagError), .flagNegativo(flagNegativo),
    .SEL_OP(op1), .srcA_SEL(a1), .srcB_SEL(b1), .reg_we(rwe1), .pc_we(pwe1),
    .pc_src(psrc1), .done(done1), .trap(trap1)
  );

  alu_seq_ctrl #(.TRAP_ON_ERROR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(rdy0),
    .flagC(flagC), .flagZ(flagZ), .flagError(flagError), .flagNegativo(flagNegativo),
    .SEL_OP(op0), .srcA_SEL(a0), .srcB_SEL(b0), .reg_we(rwe0), .pc_we(pwe0),
    .pc_src(psrc0), .done(done0), .trap(trap0)
  );

  typedef struct {
    int         cyc;
    bit         ctl;   // instruction was legal, so SEL_OP/srcA/srcB are defined
    bit         trp;
    logic [3:0] op;
    bit         a;
    bit         b;
    bit         rwe;
    bit         psrc;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  exp_t m1, m0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = -1;
  bit last_legal = 1'b0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what the instruction means under the ISA rules, and when it should finish.
  function automatic exp_t model(input logic [31:0] ins, input bit fc, input bit fz,
                                 input bit fe, input bit fn, input bit toe, input int k);
    exp_t       e;
    logic [3:0] tab [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         legal, br, cond, taken;
    tab = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    e.op = 4'd0; e.a = 0; e.b = 0; legal = 0; br = 0; taken = 0;
    case (opc)
      7'h33: begin
        legal = (f7 == 7'h00) || (f7 == 7'h20);
        e.op  = tab[f3];
        if (f7[5] && f3 == 3'd0) e.op = 4'd1;
        if (f7[5] && f3 == 3'd5) e.op = 4'd7;
      end
      7'h13: begin
        legal = 1; e.b = 1;
        e.op  = tab[f3];
        if (f7[5] && f3 == 3'd5) e.op = 4'd7;
      end
      7'h17: begin
        legal = 1; e.a = 1; e.b = 1;
      end
`ifdef ALU_SEQ_BRANCH_EN
      7'h63: begin
        legal = (f3 != 3'd2) && (f3 != 3'd3);
        br    = 1;
        e.op  = 4'd1;
        // eq / signed-lt / unsigned-lt (borrow = !C), low funct3 bit inverts
        cond  = f3[2] ? (f3[1] ? !fc : fn) : fz;
        taken = cond ^ f3[0];
      end
`endif
      default: legal = 0;
    endcase
    e.ctl = legal;
    if (!legal) begin
      e.trp = 1; e.cyc = k + 1; e.rwe = 0; e.psrc = 0;
    end else if (fe && toe) begin
      e.trp = 1; e.cyc = k + 2; e.rwe = 0; e.psrc = 0;
    end else begin
      e.trp = 0; e.cyc = k + 2; e.rwe = !br; e.psrc = br && taken;
    end
    return e;
  endfunction

  task automatic compare(input string tag, input logic [3:0] op, input logic a, input logic b,
                         input logic rwe, input logic pwe, input logic psrc,
                         input logic dn, input logic tp, input exp_t e);
    chk($sformatf("%s_cycle", tag), cyc, e.cyc);
    chk($sformatf("%s_trap", tag), tp, e.trp);
    chk($sformatf("%s_done", tag), dn, !e.trp);
    chk($sformatf("%s_pc_we", tag), pwe, !e.trp);
    chk($sformatf("%s_reg_we", tag), rwe, e.rwe);
    if (!e.trp) begin
      chk($sformatf("%s_pc_src", tag), psrc, e.psrc);
      chk($sformatf("%s_sel_op", tag), op, e.op);
      chk($sformatf("%s_srcA", tag), a, e.a);
      chk($sformatf("%s_srcB", tag), b, e.b);
    end
  endtask

  // Monitor: any strobe must match the oldest pending expectation of that instance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done1 | trap1 | rwe1 | pwe1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1_unexpected_strobe: got done=%b trap=%b reg_we=%b pc_we=%b expected none (cycle %0d)",
                   done1, trap1, rwe1, pwe1, cyc);
        end else begin
          m1 = q1.pop_front();
          compare("dut1", op1, a1, b1, rwe1, pwe1, psrc1, done1, trap1, m1);
        end
      end
      if (done0 | trap0 | rwe0 | pwe0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut0_unexpected_strobe: got done=%b trap=%b reg_we=%b pc_we=%b expected none (cycle %0d)",
                   done0, trap0, rwe0, pwe0, cyc);
        end else begin
          m0 = q0.pop_front();
          compare("dut0", op0, a0, b0, rwe0, pwe0, psrc0, done0, trap0, m0);
        end
      end
    end
  end

  // Called on a negedge; returns on the negedge where the DUT is back in IDLE.
  task automatic issue(input logic [31:0] ins, input bit fc, input bit fz, input bit fe, input bit fn);
    int   k;
    int   n;
    exp_t e;
    n = 0;
    while (rdy1 !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (rdy1 !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got instr_ready=%b expected 1", rdy1);
      return;
    end
    instr = ins; instr_valid = 1'b1;
    flagC = fc; flagZ = fz; flagError = fe; flagNegativo = fn;
    @(posedge clk);
    #1;
    k = cyc;
    if (n == 0 && last_acc >= 0) chk("accept_interval", k - last_acc, last_legal ? 4 : 3);
    e = model(ins, fc, fz, fe, fn, 1'b1, k);
    q1.push_back(e);
    q0.push_back(model(ins, fc, fz, fe, fn, 1'b0, k));
    @(negedge clk);
    chk("ready_busy", rdy1, 1'b0);
    instr = $urandom;   // valid held high with junk: must not be taken while busy
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (rdy1 === 1'b1) break;
      instr = $urandom;
    end while (n < 8);
    instr_valid = 1'b0;
    if (rdy1 !== 1'b1) begin
      checks++; errors++;
      $display("FAIL done_timeout: got instr_ready=%b expected 1", rdy1);
    end
    last_acc = k;
    last_legal = e.ctl;
  endtask

  // Abort an ADD with reset during DECODE (stage 1) or EXECUTE (stage 2).
  task automatic reset_mid(input int stage);
    instr = 32'h002081B3; instr_valid = 1'b1; flagError = 1'b0;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    if (stage == 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk($sformatf("rst_mid%0d_ready1", stage), rdy1, 1'b1);
    chk($sformatf("rst_mid%0d_ready0", stage), rdy0, 1'b1);
    chk($sformatf("rst_mid%0d_sel_op", stage), {op1, a1, b1}, 6'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    last_acc = -1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  f7;
    logic [2:0]  f3;
    int          sel;
    r   = $urandom;
    f3  = r[14:12];
    sel = $urandom_range(0, 9);
    if (sel <= 2) begin
      f7 = ($urandom_range(0, 4) == 0) ? r[31:25] : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
      r  = {f7, r[24:15], f3, r[11:7], 7'h33};
    end else if (sel <= 5) begin
      f7 = r[31:25];
      if (f3 == 3'd1) f7 = 7'h00;
      if (f3 == 3'd5) f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      r  = {f7, r[24:15], f3, r[11:7], 7'h13};
    end else if (sel == 6) begin
      r  = {r[31:7], 7'h17};
    end else if (sel <= 8) begin
      r  = {r[31:15], f3, r[11:7], 7'h63};
    end else begin
      if (r[6:0] == 7'h33 || r[6:0] == 7'h13 || r[6:0] == 7'h17 || r[6:0] == 7'h63)
        r[6] = ~r[6];
    end
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0;
    flagC = 0; flagZ = 0; flagError = 0; flagNegativo = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs1", {op1, a1, b1, rwe1, pwe1, psrc1, done1, trap1, rdy1}, 12'h001);
    chk("reset_outs0", {op0, a0, b0, rwe0, pwe0, psrc0, done0, trap0, rdy0}, 12'h001);
    mon_en = 1'b1;

    issue(32'h002081B3, 0, 0, 0, 0);   // ADD x3,x1,x2
    issue(32'h402081B3, 0, 0, 0, 0);   // SUB
    issue(32'h4020D093, 0, 0, 0, 0);   // SRAI
    issue(32'h00001097, 0, 0, 0, 0);   // AUIPC
    issue(32'h0000007F, 0, 0, 0, 0);   // illegal opcode
    issue(32'h002081B3, 0, 0, 1, 0);   // ALU error: trap vs retire
    issue(32'h00208063, 0, 1, 0, 0);   // BEQ, Z=1
    issue(32'h00208063, 0, 0, 0, 0);   // BEQ, Z=0
    issue(32'h0020E063, 0, 0, 0, 0);   // BLTU, C=0 (borrow)
    issue(32'h0020A063, 0, 0, 0, 0);   // funct3 010 branch
    issue(32'h00A0F093, 1, 1, 0, 1);   // ANDI
    reset_mid(1);
    reset_mid(2);

    for (int i = 0; i < 300; i++)
      issue(rand_instr(), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1));

    repeat (4) @(negedge clk);
    chk("pending_dut1", q1.size(), 0);
    chk("pending_dut0", q0.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
